moving_avg_filter: RTL and testbench
====================================

# moving_avg_filter

Stereo N-point moving-average (FIR) noise filter between the audio CODEC's ADC read port and its DAC write port. It accepts 24-bit signed left/right samples when the CODEC reports read data ready and produces filtered samples for the CODEC write port. Each channel keeps a circular window of 2^LOG2_N pre-scaled samples and a running accumulator, so each output needs one add and one subtract instead of N adds.

## Interface
- LOG2_N, default 3: window length N = 2^LOG2_N; legal range 1..6.
- DW, default 24: sample width, two's complement.

- clock  in  1  system clock (CLOCK_50); all logic on its rising edge.
- reset  in  1  synchronous, active-low (0 = reset), sampled on rising edge of clock.
- in_valid  in  1  input sample pair present (CODEC read_ready).
- in_ready  out  1  block accepts a pair this cycle (drives CODEC read).
- in_left, in_right  in  DW each  input samples (readdata_left/right).
- out_valid  out  1  filtered pair present.
- out_ready  in  1  consumer takes the pair this cycle (CODEC write_ready).
- out_left, out_right  out  DW each  filtered samples (writedata_left/right).
- fill_count  out  LOG2_N+1  samples currently in the window, 0..N (debug).

## Operation
- Accept: a pair is accepted when in_valid && in_ready at a rising edge.
- Per channel on accept:
  - s = x >>> LOG2_N (arithmetic shift, sign preserved, rounds toward −inf).
  - Window not full (fill_count < N): write s at wr_ptr, acc ← acc + s, fill_count++.
  - Window full: old = window[wr_ptr]; write s; acc ← acc + s − old.
  - wr_ptr increments modulo N, wrapping N−1 → 0.
- Output: the accumulator result is registered into out_left/out_right, and out_valid is set.
- Arithmetic: acc is DW bits. The sum of N values each ≤ 2^(DW−1−LOG2_N) in magnitude cannot overflow, so no saturation is needed.
- Both channels share a single wr_ptr, fill_count and handshake.
- Output register states:
  - EMPTY: out_valid=0.
  - HOLD: out_valid=1; out data stable until out_ready.
- EMPTY → HOLD on accept.
- HOLD → EMPTY on out_ready with no accept.
- HOLD → HOLD on out_ready with a simultaneous accept; the new pair is loaded.
- in_ready = !out_valid || out_ready. This allows back-to-back flow at one pair per cycle.
- Stall: while out_valid && !out_ready:
  - in_ready=0;
  - window, acc, pointers and outputs are frozen;
  - in_* data is ignored.

## Timing
- Reset (reset=0 at an edge): at that edge, all of the following clear:
  - out_valid=0, out_left=out_right=0;
  - in_ready=1 on the following cycle;
  - acc=0, wr_ptr=0, fill_count=0;
  - all window entries 0.
- Reset takes priority over any handshake in the same cycle.
- Reset mid-stream discards the window. The next output is s of the first post-reset sample.
- Latency: a pair accepted at edge k appears on out_* with out_valid=1 immediately after edge k. It includes that sample's contribution.
- Throughput: 1 pair/cycle when out_ready is held at 1. The CODEC rate (~48 kHz) is far below this.
- Window memory: one read (old) and one write at wr_ptr in the same cycle. Read-before-write semantics are required; implement as registers or as RAM with read-old-data behaviour.

## Configuration
- MOVING_AVG_BYPASS_EN defined:
  - window, accumulator and pointers are not compiled;
  - out_left/out_right ← in_left/in_right unscaled on accept;
  - identical handshake and latency;
  - fill_count held at 0.
- Undefined (default): full moving-average filter as above.

## Test plan
- Reset/fill (LOG2_N=3): constant in_left=800, in_right=−800, out_ready=1.
  - Outputs must be 100,200,…,800 and −100,…,−800 over the first 8 accepts.
  - Then steady at 800/−800; fill_count saturates at 8.
- Step down: after 8 samples of 800, feed 8 samples of 0 → outputs 700,600,…,0, checking the wr_ptr wrap 7→0.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1.
  - in_ready=0 and out_* stable for the whole hold.
  - Releasing out_ready gives exactly one accept per cycle, with no lost or duplicated samples versus a reference model.
- Simultaneous events: out_ready=1 and in_valid=1 every cycle for 20 cycles of random data → out_valid stays 1 and each output matches the model.
- Reset mid-operation: after 5 samples of 800, assert reset for 1 cycle, then send 400.
  - First output 50; fill_count=1.
- Bypass build with MOVING_AVG_BYPASS_EN defined: input 0x7FFFFF/0x800000 → output the same values one edge later; fill_count=0.

Source files
------------

// File: rtl/moving_avg_filter.sv
// Stereo N-point moving-average filter between the CODEC ADC read port and DAC write port.
// Define MOVING_AVG_BYPASS_EN to compile a pass-through with the same handshake instead.
module moving_avg_filter #(
  parameter int LOG2_N = 3,
  parameter int DW     = 24
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_left,
  input  logic signed [DW-1:0] in_right,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_left,
  output logic signed [DW-1:0] out_right,
  output logic [LOG2_N:0]      fill_count
);

  logic out_valid_reg;
  logic accept;

  // Output stage frees up in the same cycle the consumer takes the held pair.
  assign in_ready  = !out_valid_reg || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_reg;

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      out_valid_reg <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

`ifndef MOVING_AVG_BYPASS_EN
  localparam int N = 1 << LOG2_N;
  localparam logic [LOG2_N:0] N_FILL = (LOG2_N + 1)'(N);

  logic [LOG2_N-1:0] wr_ptr_reg;
  logic [LOG2_N:0]   fill_count_reg;
  logic              window_full;

  assign window_full = (fill_count_reg == N_FILL);
  assign fill_count  = fill_count_reg;

  // Shared pointer; N is a power of two so the natural wrap gives modulo N.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      wr_ptr_reg     <= '0;
      fill_count_reg <= '0;
    end else if (accept) begin
      wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (!window_full) begin
        fill_count_reg <= fill_count_reg + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    logic signed [DW-1:0] win_reg [N];
    logic signed [DW-1:0] acc_reg;
    logic signed [DW-1:0] out_reg;
    logic signed [DW-1:0] sample;
    logic signed [DW-1:0] scaled;
    logic signed [DW-1:0] old_sample;
    logic signed [DW-1:0] acc_next;

    assign sample     = (gi == 0) ? in_left : in_right;
    assign scaled     = sample >>> LOG2_N;
    // Read-before-write: the evicted entry is the one about to be overwritten.
    assign old_sample = window_full ? win_reg[wr_ptr_reg] : '0;
    assign acc_next   = acc_reg + scaled - old_sample;

    always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
        acc_reg <= '0;
        out_reg <= '0;
        for (int i = 0; i < N; i++) begin
          win_reg[i] <= '0;
        end
      end else if (accept) begin
        win_reg[wr_ptr_reg] <= scaled;
        acc_reg             <= acc_next;
        out_reg             <= acc_next;
      end
    end
  end

  assign out_left  = g_ch[0].out_reg;
  assign out_right = g_ch[1].out_reg;
`else
  assign fill_count = '0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    logic signed [DW-1:0] out_reg;
    logic signed [DW-1:0] sample;

    assign sample = (gi == 0) ? in_left : in_right;

    always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
        out_reg <= '0;
      end else if (accept) begin
        out_reg <= sample;
      end
    end
  end

  assign out_left  = g_ch[0].out_reg;
  assign out_right = g_ch[1].out_reg;
`endif

endmodule

// File: tb/tb_moving_avg_filter.sv
// Self-checking bench for moving_avg_filter: vector table plus scoreboard-checked sequences.
module tb_moving_avg_filter;
  localparam int LOG2_N = 3;
  localparam int DW     = 24;
  localparam int N      = 1 << LOG2_N;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_left;
  logic signed [DW-1:0] in_right;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_left;
  logic signed [DW-1:0] out_right;
  logic [LOG2_N:0]      fill_count;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  moving_avg_filter #(.LOG2_N(LOG2_N), .DW(DW)) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_left   (in_left),
    .in_right  (in_right),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_left  (out_left),
    .out_right (out_right),
    .fill_count(fill_count)
  );

  typedef struct {
    int l;
    int r;
    int fill;
  } exp_t;

  typedef struct {
    int in_l;
    int in_r;
    int exp_l;
    int exp_r;
    int exp_fill;
  } vec_t;

  exp_t exp_q[$];
  int   hist_l[$];
  int   hist_r[$];

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference: sum of the last N pre-scaled samples, kept as a history list.
  function automatic exp_t model_step(input int l, input int r);
    exp_t e;
    int sl;
    int sr;
`ifdef MOVING_AVG_BYPASS_EN
    e.l = l;
    e.r = r;
    e.fill = 0;
`else
    sl = l >>> LOG2_N;
    sr = r >>> LOG2_N;
    hist_l.push_back(sl);
    hist_r.push_back(sr);
    if (hist_l.size() > N) begin
      void'(hist_l.pop_front());
      void'(hist_r.pop_front());
    end
    e.l = 0;
    e.r = 0;
    foreach (hist_l[k]) e.l += hist_l[k];
    foreach (hist_r[k]) e.r += hist_r[k];
    e.fill = hist_l.size();
`endif
    return e;
  endfunction

  // Scoreboard: compare delivered pairs, then predict the pair accepted at the next edge.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got l=%0d r=%0d expected no output", out_left, out_right);
      end else begin
        e = exp_q.pop_front();
        $display("out l=%0d r=%0d fill=%0d | exp l=%0d r=%0d fill=%0d",
                 out_left, out_right, fill_count, e.l, e.r, e.fill);
        chk("sb_left", longint'(out_left), longint'(e.l));
        chk("sb_right", longint'(out_right), longint'(e.r));
        chk("sb_fill", longint'(fill_count), longint'(e.fill));
      end
    end
    if (!reset) begin
      exp_q.delete();
      hist_l.delete();
      hist_r.delete();
    end else if (in_valid && in_ready) begin
      exp_q.push_back(model_step(int'(in_left), int'(in_right)));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_in();
    in_left  = DW'($urandom());
    in_right = DW'($urandom());
  endtask

  initial begin
    vec_t tbl[19];
    logic signed [DW-1:0] hold_l;
    logic signed [DW-1:0] hold_r;

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_left   = '0;
    in_right  = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_left", longint'(out_left), 0);
    chk("rst_out_right", longint'(out_right), 0);
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_fill", longint'(fill_count), 0);
    reset = 1'b1;
    tick();

`ifdef MOVING_AVG_BYPASS_EN
    in_valid = 1'b1;
    in_left  = 24'sh7FFFFF;
    in_right = 24'sh800000;
    tick();
    in_valid = 1'b0;
    chk("byp_valid", longint'(out_valid), 1);
    chk("byp_left", longint'(out_left), 64'sd8388607);
    chk("byp_right", longint'(out_right), -64'sd8388608);
    chk("byp_fill", longint'(fill_count), 0);
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      rand_in();
      tick();
    end
    in_valid = 1'b0;
`else
    // Fill with 800/-800, hold steady, then step down to 0 across the pointer wrap.
    for (int i = 0; i < 19; i++) begin
      if (i < 11) begin
        tbl[i].in_l = 800;
        tbl[i].in_r = -800;
        tbl[i].exp_l = (i < 8) ? 100 * (i + 1) : 800;
        tbl[i].exp_r = -tbl[i].exp_l;
      end else begin
        tbl[i].in_l = 0;
        tbl[i].in_r = 0;
        tbl[i].exp_l = 800 - 100 * (i - 10);
        tbl[i].exp_r = -tbl[i].exp_l;
      end
      tbl[i].exp_fill = (i < 8) ? i + 1 : 8;
    end
    for (int i = 0; i < 19; i++) begin
      in_valid = 1'b1;
      in_left  = DW'(tbl[i].in_l);
      in_right = DW'(tbl[i].in_r);
      tick();
      chk($sformatf("tbl%0d_valid", i), longint'(out_valid), 1);
      chk($sformatf("tbl%0d_left", i), longint'(out_left), longint'(tbl[i].exp_l));
      chk($sformatf("tbl%0d_right", i), longint'(out_right), longint'(tbl[i].exp_r));
      chk($sformatf("tbl%0d_fill", i), longint'(fill_count), longint'(tbl[i].exp_fill));
    end

    // Backpressure: in_ready low and output frozen while new input data churns.
    out_ready = 1'b0;
    hold_l = out_left;
    hold_r = out_right;
    rand_in();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_in_ready", longint'(in_ready), 0);
      chk("bp_valid", longint'(out_valid), 1);
      chk("bp_left", longint'(out_left), longint'(hold_l));
      chk("bp_right", longint'(out_right), longint'(hold_r));
      tick();
      rand_in();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rel_in_ready", longint'(in_ready), 1);
      tick();
      rand_in();
    end

    // Back-to-back random traffic with out_ready held high.
    for (int k = 0; k < 20; k++) begin
      rand_in();
      @(negedge clk);
      chk("b2b_valid", longint'(out_valid), 1);
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();

    // Reset mid-stream discards the window.
    in_valid = 1'b1;
    in_left  = 24'sd800;
    in_right = -24'sd800;
    repeat (5) tick();
    in_valid = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_rst_valid", longint'(out_valid), 0);
    chk("mid_rst_fill", longint'(fill_count), 0);
    in_valid = 1'b1;
    in_left  = 24'sd400;
    in_right = -24'sd400;
    tick();
    in_valid = 1'b0;
    chk("mid_rst_left", longint'(out_left), 50);
    chk("mid_rst_right", longint'(out_right), -50);
    chk("mid_rst_fill1", longint'(fill_count), 1);
`endif

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    chk("sb_drained", longint'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
